// File: rtl/mem_boot_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_boot_arbiter_if
//   Bundles every handshake and SRAM-side signal of mem_boot_arbiter. Signal
//   names keep the arbiter's point of view (_i = into the arbiter, _o = out).
//
//   Groups:
//     boot   : fetch_enable_i, fetch_enable_o, en_ifetch_o, boot_done_o
//     spi    : spi_req/we/addr/wdata_i, spi_gnt/rvalid/rdata_o
//     instr  : instr_req/addr_i, instr_gnt/rvalid/rdata_o
//     data   : data_req/we/be/addr/wdata_i, data_gnt/rvalid/rdata_o
//     sram   : mem_req/we/be/addr/wdata_o, mem_rdata_i
//
//   Modports:
//     slave  : the arbiter itself
//     master : the environment (core, SPI loader, SRAM)
// -----------------------------------------------------------------------------
interface mem_boot_arbiter_if #(
    parameter int AW = 10
);
    logic          fetch_enable_i;
    logic          fetch_enable_o;
    logic          en_ifetch_o;
    logic          boot_done_o;

    logic          spi_req_i;
    logic          spi_we_i;
    logic [31:0]   spi_addr_i;
    logic [31:0]   spi_wdata_i;
    logic          spi_gnt_o;
    logic          spi_rvalid_o;
    logic [31:0]   spi_rdata_o;

    logic          instr_req_i;
    logic [31:0]   instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;

    logic          data_req_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [31:0]   data_addr_i;
    logic [31:0]   data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;

    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    modport slave (
        input  fetch_enable_i,
        output fetch_enable_o, en_ifetch_o, boot_done_o,
        input  spi_req_i, spi_we_i, spi_addr_i, spi_wdata_i,
        output spi_gnt_o, spi_rvalid_o, spi_rdata_o,
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output fetch_enable_i,
        input  fetch_enable_o, en_ifetch_o, boot_done_o,
        output spi_req_i, spi_we_i, spi_addr_i, spi_wdata_i,
        input  spi_gnt_o, spi_rvalid_o, spi_rdata_o,
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// mem_boot_arbiter
//   Owns the single-port instruction/data SRAM and sequences the boot.
//   LOAD : only the SPI loader reaches the SRAM.
//   RUN  : entered on fetch_enable_i or (AUTO_BOOT) an SPI write of END_MARKER;
//          fixed priority data > instr > spi, with an anti-starvation override
//          that hands the SRAM to SPI after STARVE_LIMIT denied cycles.
//   Grants are combinational; the winner is registered so its response
//   (rvalid + mem_rdata_i) is routed back one cycle later, fully pipelined.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   bus     : mem_boot_arbiter_if.slave (boot, spi, instr, data, sram groups)
// -----------------------------------------------------------------------------
module mem_boot_arbiter #(
    parameter int          AW           = 10,
    parameter logic [31:0] END_MARKER   = 32'h00000fff,
    parameter bit          AUTO_BOOT    = 1'b1,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    mem_boot_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        LOAD,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_SPI,
        OWN_INSTR,
        OWN_DATA
    } owner_e;

    state_e        state_q, state_d;
    owner_e        winner, owner_q;
    logic [CW-1:0] starve_q;
    logic          boot_done_q;
    logic          fetch_en_q;
    logic          en_ifetch_q;
    logic          spi_starved;
    logic          marker_write;

    assign spi_starved  = bus.spi_req_i && (starve_q == CW'(STARVE_LIMIT));
    assign marker_write = AUTO_BOOT && (winner == OWN_SPI) && bus.spi_we_i
                          && (bus.spi_wdata_i == END_MARKER);

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: if (bus.fetch_enable_i || marker_write) state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = LOAD;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Winner selection and SRAM field mux.
    always_comb begin
        winner          = OWN_NONE;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;

        if (state_q == LOAD) begin
            if (bus.spi_req_i) winner = OWN_SPI;
        end else if (spi_starved) begin
            winner = OWN_SPI;
        end else if (bus.data_req_i) begin
            winner = OWN_DATA;
        end else if (bus.instr_req_i) begin
            winner = OWN_INSTR;
        end else if (bus.spi_req_i) begin
            winner = OWN_SPI;
        end

        unique case (winner)
            OWN_SPI: begin
                bus.mem_we_o    = bus.spi_we_i;
                bus.mem_be_o    = 4'hF;
                bus.mem_addr_o  = bus.spi_addr_i[AW+1:2];
                bus.mem_wdata_o = bus.spi_wdata_i;
            end
            OWN_INSTR: begin
                bus.mem_be_o    = 4'hF;
                bus.mem_addr_o  = bus.instr_addr_i[AW+1:2];
            end
            OWN_DATA: begin
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_addr_o  = bus.data_addr_i[AW+1:2];
                bus.mem_wdata_o = bus.data_wdata_i;
            end
            default: ;
        endcase
    end

    assign bus.spi_gnt_o   = (winner == OWN_SPI);
    assign bus.instr_gnt_o = (winner == OWN_INSTR);
    assign bus.data_gnt_o  = (winner == OWN_DATA);
    assign bus.mem_req_o   = bus.spi_gnt_o | bus.instr_gnt_o | bus.data_gnt_o;

    // ---------------------------------------------------------------- datapath regs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            boot_done_q <= 1'b0;
            fetch_en_q  <= 1'b0;
            en_ifetch_q <= 1'b0;
        end else begin
            owner_q <= winner;

            if (!bus.spi_req_i || winner == OWN_SPI) begin
                starve_q <= '0;
            end else if (starve_q != CW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + CW'(1);
            end

            // RUN is never left, so these flags are sticky until reset.
            if (state_d == RUN) begin
                boot_done_q <= 1'b1;
                fetch_en_q  <= 1'b1;
            end
            en_ifetch_q <= bus.fetch_enable_i | boot_done_q;
        end
    end

    assign bus.boot_done_o    = boot_done_q;
    assign bus.fetch_enable_o = fetch_en_q;
    assign bus.en_ifetch_o    = en_ifetch_q;

    // ---------------------------------------------------------------- responses
    // Gated by rst_ni so a response pending when reset hits is dropped even in
    // the cycle reset is first applied.
    assign bus.spi_rvalid_o   = rst_ni && (owner_q == OWN_SPI);
    assign bus.instr_rvalid_o = rst_ni && (owner_q == OWN_INSTR);
    assign bus.data_rvalid_o  = rst_ni && (owner_q == OWN_DATA);

    assign bus.spi_rdata_o    = bus.spi_rvalid_o   ? bus.mem_rdata_i : '0;
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.data_rdata_o   = bus.data_rvalid_o  ? bus.mem_rdata_i : '0;

    // Address bits outside the word index are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.spi_addr_i[31:AW+2],   bus.spi_addr_i[1:0],
                                bus.instr_addr_i[31:AW+2], bus.instr_addr_i[1:0],
                                bus.data_addr_i[31:AW+2],  bus.data_addr_i[1:0]};

endmodule

// File: doc/mem_boot_arbiter.md
Name: mem_boot_arbiter

Overview:
- Owns the single-port instruction/data SRAM inside top_core and sequences the boot.
- After reset, only the SPI loader may access the SRAM. Program words arrive over SPI write commands.
- On an external fetch enable, or when the end-of-program marker word is written, the block releases the core.
- After release it arbitrates the SRAM between the core data port, the core instruction port and the SPI loader, and routes read responses back to the correct requester.

Parameters:
- AW, 10, SRAM word-address width (memory = 2^AW 32-bit words).
- END_MARKER, 32'h00000fff, SPI write data value that completes the load.
- AUTO_BOOT, 1, 1 = writing END_MARKER triggers boot; 0 = only fetch_enable_i triggers boot.
- STARVE_LIMIT, 8, consecutive denied cycles after which the SPI request wins arbitration in RUN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- fetch_enable_i  in  1  external boot request (level, sampled)
- spi_req_i  in  1  SPI loader request
- spi_we_i  in  1  SPI write enable
- spi_addr_i  in  32  SPI byte address
- spi_wdata_i  in  32  SPI write data
- spi_gnt_o  out  1  SPI grant
- spi_rvalid_o  out  1  SPI response valid
- spi_rdata_o  out  32  SPI read data
- instr_req_i  in  1  core instruction request (read only)
- instr_addr_i  in  32  core instruction byte address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- data_req_i  in  1  core data request
- data_we_i  in  1  core data write enable
- data_be_i  in  4  core data byte enables
- data_addr_i  in  32  core data byte address
- data_wdata_i  in  32  core data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  AW  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data (valid 1 cycle after a granted read)
- fetch_enable_o  out  1  core fetch enable
- en_ifetch_o  out  1  core instruction-fetch enable
- boot_done_o  out  1  sticky boot-complete flag

Behaviour:
- Reset (rst_ni=0 at posedge):
  - state=LOAD; every *_rvalid_o=0; fetch_enable_o=0, en_ifetch_o=0, boot_done_o=0.
  - starvation counter=0; owner register=NONE.
  - A reset mid-transfer drops any pending response; no rvalid is issued after reset.
- Grants are combinational, same cycle as the request.
  - At most one of spi_gnt_o, instr_gnt_o, data_gnt_o is high.
  - mem_req_o = OR of the grants; mem_* fields are muxed from the winner.
- Address mapping: mem_addr_o = addr[AW+1:2]. Upper bits are ignored, so addresses wrap modulo 2^AW words.
- Byte enables: SPI accesses always use be=4'hF.
- Response routing:
  - The owner is registered at grant time. In the next cycle, the owner's rvalid=1 and its rdata=mem_rdata_i.
  - Writes also return rvalid (rdata don't-care).
  - Every rdata output of a non-owner is 0.
  - Back-to-back grants are allowed: one outstanding transaction per cycle, fully pipelined.
- FSM LOAD:
  - Only SPI may be granted; instr_gnt_o=data_gnt_o=0 regardless of core requests.
  - Go to RUN when fetch_enable_i=1, or when AUTO_BOOT=1 and a granted SPI write carries spi_wdata_i==END_MARKER. The marker write itself is performed.
  - The transition takes effect at the next posedge. If both triggers occur in the same cycle, the result is the same single transition.
- FSM RUN:
  - Entry sets boot_done_o=1 and fetch_enable_o=1 from the first RUN cycle. All three are registered and sticky until reset.
  - en_ifetch_o = fetch_enable_i OR boot_done_o, registered.
  - Dropping fetch_enable_i does not leave RUN.
- Arbitration in RUN:
  - Fixed priority data > instr > spi.
  - Starvation counter: increments each cycle spi_req_i=1 and SPI is not granted. It resets to 0 on SPI grant or when spi_req_i=0, and saturates at STARVE_LIMIT.
  - When counter==STARVE_LIMIT and spi_req_i=1, SPI wins that cycle over both core ports.
- No state exits RUN except reset.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with all requests high.
  - After release: every rvalid, fetch_enable_o and boot_done_o = 0; spi_gnt_o=1; instr_gnt_o=0.
- Load: SPI writes 0x13 to byte addresses 0x80..0xFC while instr_req_i=1.
  - Every SPI write is granted in the same cycle; instr_gnt_o stays 0; mem_addr_o=0x20..0x3F; spi_rvalid_o pulses one cycle after each grant.
- Auto-boot: SPI writes 32'h00000fff to 0x84.
  - The write reaches the SRAM; boot_done_o=1 and fetch_enable_o=1 on the following cycle.
  - With AUTO_BOOT=0, the state stays LOAD until fetch_enable_i pulses 1 cycle; fetch_enable_o stays 1 after fetch_enable_i drops.
- Priority/routing in RUN: data read 0x100, instr read 0x80 and SPI read requested in the same cycle.
  - data_gnt_o only; next cycle data_rvalid_o=1 with the SRAM word at index 0x40.
  - Instr is granted next; instr_rvalid_o follows; instr_rdata_o=0x13.
- Starvation: data_req_i and spi_req_i held high continuously with STARVE_LIMIT=8.
  - spi_gnt_o=1 exactly in the 9th cycle of SPI request; the counter then restarts.
- Reset mid-operation: assert rst_ni=0 in the cycle after an instr grant.
  - No instr_rvalid_o; the state returns to LOAD; boot_done_o=0.
